// File: rtl/seq_divider.sv
// seq_divider: signed 64/32 restoring divider, one quotient bit per enabled cycle.
// Quotient saturates on overflow; divide-by-zero returns the low dividend word as remainder.
module seq_divider #(
    parameter int DW = 64,
    parameter int QW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [QW-1:0] divisor,
    output logic [QW-1:0] quotient,
    output logic [QW-1:0] remainder,
    output logic          busy,
    output logic          done,
    output logic          div_by_zero,
    output logic          overflow
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3;
    logic [1:0]    state_q, state_d;
    logic [6:0]    cnt_q, cnt_d;
    logic [DW-1:0] dvd_q, dvd_d, pq_q, pq_d, q_lim;
    logic [QW-1:0] dvs_q, dvs_d, quo_q, quo_d, rem_q, rem_d;
    logic [QW:0]   pr_q, pr_d;
    logic [QW+1:0] diff;
    logic          qneg_q, qneg_d, rneg_q, rneg_d, done_q, done_d;
    logic          dbz_q, dbz_d, ovf_q, ovf_d, q_ovf;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        pq_d    = pq_q;
        pr_d    = pr_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        done_d  = (state_q == FIX) || (state_q == DONE && !done_q);
        // Partial remainder stays below |divisor|, so the 34-bit sign is a clean borrow.
        diff    = {pr_q, dvd_q[DW-1]} - {2'b00, dvs_q};
        q_lim   = qneg_q ? {{(DW-QW){1'b0}}, 1'b1, {(QW-1){1'b0}}}
                         : {{(DW-QW+1){1'b0}}, {(QW-1){1'b1}}};
        q_ovf   = pq_q > q_lim;
        case (state_q)
            IDLE: if (start) begin
                dvd_d  = dividend[DW-1] ? -dividend : dividend;
                dvs_d  = divisor[QW-1] ? -divisor : divisor;
                qneg_d = dividend[DW-1] ^ divisor[QW-1];
                rneg_d = dividend[DW-1];
                pq_d   = '0;
                pr_d   = '0;
                cnt_d  = '0;
                state_d = (divisor == '0) ? DONE : RUN;
                if (divisor == '0) begin
                    quo_d = '0;
                    rem_d = dividend[QW-1:0];
                    dbz_d = 1'b1;
                    ovf_d = 1'b0;
                end
            end
            RUN: begin
                dvd_d   = dvd_q << 1;
                pq_d    = {pq_q[DW-2:0], ~diff[QW+1]};
                pr_d    = diff[QW+1] ? {pr_q[QW-1:0], dvd_q[DW-1]} : diff[QW:0];
                cnt_d   = cnt_q + 7'd1;
                state_d = (cnt_q == 7'd63) ? FIX : RUN;
            end
            FIX: begin
                quo_d   = q_ovf ? (qneg_q ? {1'b1, {(QW-1){1'b0}}} : {1'b0, {(QW-1){1'b1}}})
                                : (qneg_q ? -pq_q[QW-1:0] : pq_q[QW-1:0]);
                rem_d   = rneg_q ? -pr_q[QW-1:0] : pr_q[QW-1:0];
                ovf_d   = q_ovf;
                dbz_d   = 1'b0;
                state_d = DONE;
            end
            default: state_d = done_q ? IDLE : DONE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            pq_q    <= '0;
            pr_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            pq_q    <= pq_d;
            pr_q    <= pr_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign busy        = state_q != IDLE;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vectors for seq_divider with hand-computed results.
module tb_seq_divider;
    logic        clk = 1'b0, reset = 1'b1, en = 1'b1, start = 1'b0;
    logic [63:0] dividend = '0;
    logic [31:0] divisor = '0, quotient, remainder;
    logic        busy, done, div_by_zero, overflow;
    int          n_cmp = 0, n_bad = 0;
    always #5 clk = ~clk;
    seq_divider dut (
        .clk(clk), .reset(reset), .en(en), .start(start),
        .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .overflow(overflow)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic div_case(input string tag, input logic [63:0] a, input logic [31:0] b,
                            input int exp_lat, input logic [31:0] eq, input logic [31:0] er,
                            input logic edz, input logic eov);
        int lat;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, ".busy"}, 64'(busy), 64'd1);
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
        check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        check({tag, ".q"}, 64'(quotient), 64'(eq));
        check({tag, ".r"}, 64'(remainder), 64'(er));
        check({tag, ".dbz"}, 64'(div_by_zero), 64'(edz));
        check({tag, ".ovf"}, 64'(overflow), 64'(eov));
        @(posedge clk);
        #1;
        check({tag, ".done_low"}, 64'(done), 64'd0);
        check({tag, ".idle"}, 64'(busy), 64'd0);
    endtask
    initial begin
        int nd, lat;
        #2;
        check("rst.q", 64'(quotient), 64'd0);
        check("rst.r", 64'(remainder), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.flags", 64'({div_by_zero, overflow}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        div_case("basic", 64'd464960160, 32'd840, 65, 32'd553524, 32'd0, 1'b0, 1'b0);
        div_case("negneg", -64'sd143362716, -32'sd259, 65, 32'd553524, 32'd0, 1'b0, 1'b0);
        div_case("pos_neg", 64'd7, -32'sd2, 65, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
        div_case("neg_pos", -64'sd7, 32'd2, 65, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
        div_case("ovf_pos", 64'h0000_0100_0000_0000, 32'd1, 65, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b1);
        div_case("min_neg", 64'hFFFF_FFFF_8000_0000, 32'd1, 65, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
        div_case("ovf_neg", 64'hFFFF_FFFF_7FFF_FFFF, 32'd1, 65, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
        div_case("dbz", 64'd1348760118, 32'd0, 1, 32'd0, 32'd1348760118, 1'b1, 1'b0);
        // A second start while busy must be dropped.
        @(negedge clk);
        dividend = 64'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        nd = 0;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            if (i == 10) begin
                dividend = 64'd10;
                divisor  = 32'd3;
                start    = 1'b1;
            end
            if (i == 11) start = 1'b0;
            @(posedge clk);
            #1;
            if (done) begin
                nd++;
                if (lat < 0) lat = i;
            end
        end
        check("busy_start.ndone", 64'(nd), 64'd1);
        check("busy_start.lat", 64'(lat), 64'd65);
        check("busy_start.q", 64'(quotient), 64'd14);
        check("busy_start.r", 64'(remainder), 64'd2);
        // Five disabled cycles mid-RUN stretch latency by five.
        @(negedge clk);
        dividend = 64'd1000;
        divisor  = 32'd10;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (!done && lat < 200) begin
            if (lat == 20) en = 1'b0;
            if (lat == 25) en = 1'b1;
            @(posedge clk);
            #1 lat++;
        end
        check("stall.lat", 64'(lat), 64'd70);
        check("stall.q", 64'(quotient), 64'd100);
        check("stall.r", 64'(remainder), 64'd0);
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("stall.done_hold", 64'(done), 64'd1);
        en = 1'b1;
        @(posedge clk);
        #1 check("stall.done_clr", 64'(done), 64'd0);
        // Asynchronous reset mid-operation.
        @(negedge clk);
        dividend = 64'd5000;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (30) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst.q", 64'(quotient), 64'd0);
        check("arst.r", 64'(remainder), 64'd0);
        check("arst.busy", 64'(busy), 64'd0);
        check("arst.done", 64'(done), 64'd0);
        check("arst.flags", 64'({div_by_zero, overflow}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        nd = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1 if (done) nd++;
        end
        check("arst.no_done", 64'(nd), 64'd0);
        div_case("after_rst", 64'd840, 32'd840, 65, 32'd1, 32'd0, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
